// File: rtl/updown_count_sequencer_if.sv
// updown_count_sequencer_if
//   Groups the host-side control inputs and the count/status outputs of
//   updown_count_sequencer into one bundle.
//   master : host / test controller (drives start, stop and the config fields)
//   slave  : the sequencer (drives q, dir, busy, done, pass_cnt)
//   Fields:
//     start, stop           - launch / abort requests
//     lo_lim, hi_lim [W]    - count limits, latched at start
//     passes [PW]           - number of limit-to-limit passes, latched at start
//     pingpong              - 1 = reverse at limits, 0 = wrap to lo
//     q [W]                 - registered count
//     dir                   - 0 = up, 1 = down
//     busy, done            - UP/DOWN decode, one-cycle DONE pulse
//     pass_cnt [PW]         - passes completed in current/last sequence
interface updown_count_sequencer_if #(
    parameter int W  = 3,
    parameter int PW = 4
);
    logic          start;
    logic          stop;
    logic [W-1:0]  lo_lim;
    logic [W-1:0]  hi_lim;
    logic [PW-1:0] passes;
    logic          pingpong;
    logic [W-1:0]  q;
    logic          dir;
    logic          busy;
    logic          done;
    logic [PW-1:0] pass_cnt;

    modport master (
        output start, stop, lo_lim, hi_lim, passes, pingpong,
        input  q, dir, busy, done, pass_cnt
    );

    modport slave (
        input  start, stop, lo_lim, hi_lim, passes, pingpong,
        output q, dir, busy, done, pass_cnt
    );
endinterface

// File: rtl/updown_count_sequencer.sv
// updown_count_sequencer
//   Drives a W-bit up/down count between programmable limits for a
//   programmed number of passes, either ping-ponging between the limits or
//   wrapping from hi back to lo. Each limit is shown for exactly one cycle
//   per turn.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset, overrides everything
//     bus  - updown_count_sequencer_if.slave (control in, count/status out)
module updown_count_sequencer #(
    parameter int W  = 3,
    parameter int PW = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    updown_count_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  q_q, q_d;
    logic [PW-1:0] pass_cnt_q, pass_cnt_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [PW-1:0] passes_q, passes_d;
    logic          pp_q, pp_d;

    logic [PW-1:0] pass_inc;
    logic          last_pass;

    assign pass_inc  = pass_cnt_q + PW'(1);
    assign last_pass = (pass_inc == passes_q);

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        pass_cnt_d = pass_cnt_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        passes_d   = passes_q;
        pp_d       = pp_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lo_d       = bus.lo_lim;
                    hi_d       = bus.hi_lim;
                    passes_d   = bus.passes;
                    pp_d       = bus.pingpong;
                    q_d        = bus.lo_lim;
                    pass_cnt_d = '0;
                    // Empty range or zero passes: report completion immediately.
                    if ((bus.lo_lim >= bus.hi_lim) || (bus.passes == '0))
                        state_d = S_DONE;
                    else
                        state_d = S_UP;
                end
            end
            S_UP: begin
                // Abort takes precedence over a pass completing this cycle.
                if (bus.stop) begin
                    state_d = S_DONE;
                end else if (q_q == hi_q) begin
                    pass_cnt_d = pass_inc;
                    if (last_pass) begin
                        state_d = S_DONE;
                    end else if (pp_q) begin
                        state_d = S_DOWN;
                        q_d     = hi_q - W'(1);
                    end else begin
                        q_d = lo_q;
                    end
                end else begin
                    q_d = q_q + W'(1);
                end
            end
            S_DOWN: begin
                if (bus.stop) begin
                    state_d = S_DONE;
                end else if (q_q == lo_q) begin
                    pass_cnt_d = pass_inc;
                    if (last_pass) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_UP;
                        q_d     = lo_q + W'(1);
                    end
                end else begin
                    q_d = q_q - W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            q_q        <= '0;
            pass_cnt_q <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            passes_q   <= '0;
            pp_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            pass_cnt_q <= pass_cnt_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            passes_q   <= passes_d;
            pp_q       <= pp_d;
        end
    end

    // Status outputs are pure decodes of the registered state.
    assign bus.q        = q_q;
    assign bus.pass_cnt = pass_cnt_q;
    assign bus.busy     = (state_q == S_UP) || (state_q == S_DOWN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.dir      = (state_q == S_DOWN);

endmodule

// File: tb/tb_updown_count_sequencer.sv
module tb_updown_count_sequencer;
    localparam int W  = 3;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    updown_count_sequencer_if #(.W(W), .PW(PW)) bus ();

    updown_count_sequencer #(.W(W), .PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle with the given config, then scramble the
    // config inputs so the DUT must rely on its latched copy.
    task automatic launch(input logic [W-1:0] lo, input logic [W-1:0] hi,
                          input logic [PW-1:0] np, input logic pp);
        bus.lo_lim   = lo;
        bus.hi_lim   = hi;
        bus.passes   = np;
        bus.pingpong = pp;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.lo_lim   = 3'd7;
        bus.hi_lim   = 3'd0;
        bus.passes   = 4'd0;
        bus.pingpong = ~pp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.q !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.dir !== 1'b0 || bus.pass_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state q=%0d busy=%b done=%b dir=%b pc=%0d expected 0,0,0,0,0",
                     bus.q, bus.busy, bus.done, bus.dir, bus.pass_cnt);
        end
        rst = 1'b0;
        tick();
        // Mid-sequence reset
        launch(3'd2, 3'd6, 4'd1, 1'b1);
        tick();
        tick();
        checks++;
        if (bus.q !== 3'd4 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre q=%0d busy=%b expected 4,1", bus.q, bus.busy);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.q !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
                bus.pass_cnt !== 4'd0) begin
                errors++;
                $display("FAIL reset_mid cyc%0d q=%0d busy=%b done=%b pc=%0d expected 0,0,0,0",
                         i, bus.q, bus.busy, bus.done, bus.pass_cnt);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 3'd0) begin
                errors++;
                $display("FAIL reset_after cyc%0d done=%b busy=%b q=%0d expected 0,0,0",
                         i, bus.done, bus.busy, bus.q);
            end
        end
    endtask

    task automatic test_pingpong();
        logic [2:0] eq [7]  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2};
        logic       ed [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] epc [7] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
        launch(3'd2, 3'd5, 4'd2, 1'b1);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bus.q !== eq[i] || bus.dir !== ed[i] || bus.busy !== 1'b1 ||
                bus.done !== 1'b0 || bus.pass_cnt !== epc[i]) begin
                errors++;
                $display("FAIL pingpong step%0d q=%0d dir=%b busy=%b done=%b pc=%0d expected %0d,%b,1,0,%0d",
                         i, bus.q, bus.dir, bus.busy, bus.done, bus.pass_cnt, eq[i], ed[i], epc[i]);
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== 3'd2 ||
            bus.pass_cnt !== 4'd2 || bus.dir !== 1'b0) begin
            errors++;
            $display("FAIL pingpong_done done=%b busy=%b q=%0d pc=%0d dir=%b expected 1,0,2,2,0",
                     bus.done, bus.busy, bus.q, bus.pass_cnt, bus.dir);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.q !== 3'd2 || bus.pass_cnt !== 4'd2) begin
            errors++;
            $display("FAIL pingpong_idle done=%b q=%0d pc=%0d expected 0,2,2",
                     bus.done, bus.q, bus.pass_cnt);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [2:0] eq [6] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
        launch(3'd1, 3'd3, 4'd2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.q !== eq[i] || bus.dir !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL wrap step%0d q=%0d dir=%b busy=%b expected %0d,0,1",
                         i, bus.q, bus.dir, bus.busy, eq[i]);
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.q !== 3'd3 || bus.pass_cnt !== 4'd2) begin
            errors++;
            $display("FAIL wrap_done done=%b q=%0d pc=%0d expected 1,3,2",
                     bus.done, bus.q, bus.pass_cnt);
        end
        tick();
    endtask

    task automatic test_full_range();
        launch(3'd0, 3'd7, 4'd1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.q !== 3'(i) || bus.busy !== 1'b1 || bus.dir !== 1'b0) begin
                errors++;
                $display("FAIL full step%0d q=%0d busy=%b dir=%b expected %0d,1,0",
                         i, bus.q, bus.busy, bus.dir, i);
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.q !== 3'd7 || bus.pass_cnt !== 4'd1) begin
            errors++;
            $display("FAIL full_done done=%b q=%0d pc=%0d expected 1,7,1",
                     bus.done, bus.q, bus.pass_cnt);
        end
        tick();
    endtask

    task automatic test_stop_and_start();
        launch(3'd0, 3'd6, 4'd3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            // A start with a different config while busy must be ignored.
            if (i == 2) begin
                bus.lo_lim = 3'd5;
                bus.hi_lim = 3'd6;
                bus.passes = 4'd1;
                bus.start  = 1'b1;
            end else begin
                bus.start  = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        checks++;
        if (bus.q !== 3'd6 || bus.busy !== 1'b1 || bus.dir !== 1'b0) begin
            errors++;
            $display("FAIL stop_pre q=%0d busy=%b dir=%b expected 6,1,0",
                     bus.q, bus.busy, bus.dir);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== 3'd6 ||
            bus.pass_cnt !== 4'd0) begin
            errors++;
            $display("FAIL stop_done done=%b busy=%b q=%0d pc=%0d expected 1,0,6,0",
                     bus.done, bus.busy, bus.q, bus.pass_cnt);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 3'd6) begin
            errors++;
            $display("FAIL stop_idle done=%b busy=%b q=%0d expected 0,0,6",
                     bus.done, bus.busy, bus.q);
        end
        tick();
    endtask

    task automatic test_degenerate();
        launch(3'd5, 3'd5, 4'd1, 1'b1);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== 3'd5 ||
            bus.pass_cnt !== 4'd0) begin
            errors++;
            $display("FAIL degen_eq done=%b busy=%b q=%0d pc=%0d expected 1,0,5,0",
                     bus.done, bus.busy, bus.q, bus.pass_cnt);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 3'd5) begin
            errors++;
            $display("FAIL degen_eq_idle done=%b busy=%b q=%0d expected 0,0,5",
                     bus.done, bus.busy, bus.q);
        end
        launch(3'd2, 3'd4, 4'd0, 1'b0);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== 3'd2) begin
            errors++;
            $display("FAIL degen_zero done=%b busy=%b q=%0d expected 1,0,2",
                     bus.done, bus.busy, bus.q);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 3'd2) begin
            errors++;
            $display("FAIL degen_zero_idle done=%b busy=%b q=%0d expected 0,0,2",
                     bus.done, bus.busy, bus.q);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.lo_lim   = '0;
        bus.hi_lim   = '0;
        bus.passes   = '0;
        bus.pingpong = 1'b0;
        #1;
        test_reset();
        test_pingpong();
        test_wrap();
        test_full_range();
        test_stop_and_start();
        test_degenerate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
